// File: rtl/falafel_block_writer.sv
// -----------------------------------------------------------------------------
// falafel_pkg: shared word and free-block header types for the falafel allocator.
// -----------------------------------------------------------------------------
package falafel_pkg;
  localparam int unsigned WORD_W = 64;

  typedef logic [WORD_W-1:0] word_t;

  typedef struct packed {
    word_t size;
    word_t next_ptr;
  } free_block_t;

  localparam word_t NULL_PTR = word_t'(0);
endpackage

// -----------------------------------------------------------------------------
// falafel_block_writer: writes a two-word free-block header (size, next_ptr)
// to memory as two sequential single-outstanding write beats.
//
// Ports:
//   clk_i, rst_i           clock, synchronous active-high reset
//   req_valid_i/ready_o    request handshake; ready only while idle
//   req_addr_i             byte address of the header (8-byte aligned, non-null)
//   req_block_i            header contents to write
//   mem_req_o/gnt_i        memory request handshake
//   mem_we_o/addr_o/wdata_o write beat payload, all zero when no request
//   mem_rvalid_i           write-completion ack, one per granted beat
//   done_o / err_o         one-cycle completion / rejection pulse
// -----------------------------------------------------------------------------
module falafel_block_writer
  import falafel_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  word_t       req_addr_i,
  input  free_block_t req_block_i,
  output logic        mem_req_o,
  input  logic        mem_gnt_i,
  output logic        mem_we_o,
  output word_t       mem_addr_o,
  output word_t       mem_wdata_o,
  input  logic        mem_rvalid_i,
  output logic        done_o,
  output logic        err_o
);

  localparam word_t NEXT_OFFSET = word_t'(8);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WR_SIZE   = 3'd1,
    WAIT_SIZE = 3'd2,
    WR_NEXT   = 3'd3,
    WAIT_NEXT = 3'd4,
    RESP      = 3'd5
  } state_e;

  state_e      state_q, state_d;
  word_t       addr_q, addr_d;
  free_block_t blk_q, blk_d;
  logic        err_pend_q, err_pend_d;

  logic        req_ready_q, req_ready_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  word_t       mem_addr_q, mem_addr_d;
  word_t       mem_wdata_q, mem_wdata_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  // Next state, request capture, and output values decoded from the next state
  // so every output is a flop yet follows the state with no added latency.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    blk_d       = blk_q;
    err_pend_d  = err_pend_q;
    req_ready_d = 1'b0;
    mem_req_d   = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = word_t'(0);
    mem_wdata_d = word_t'(0);
    done_d      = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          addr_d = req_addr_i;
          blk_d  = req_block_i;
          // Misaligned or null headers are rejected without touching memory.
          if (req_addr_i == NULL_PTR || req_addr_i[2:0] != 3'b000) begin
            err_pend_d = 1'b1;
            state_d    = RESP;
          end else begin
            err_pend_d = 1'b0;
            state_d    = WR_SIZE;
          end
        end
      end
      WR_SIZE:   if (mem_gnt_i)    state_d = WAIT_SIZE;
      WAIT_SIZE: if (mem_rvalid_i) state_d = WR_NEXT;
      WR_NEXT:   if (mem_gnt_i)    state_d = WAIT_NEXT;
      WAIT_NEXT: if (mem_rvalid_i) state_d = RESP;
      RESP:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase

    case (state_d)
      IDLE: req_ready_d = 1'b1;
      WR_SIZE: begin
        mem_req_d   = 1'b1;
        mem_we_d    = 1'b1;
        mem_addr_d  = addr_d;
        mem_wdata_d = blk_d.size;
      end
      WR_NEXT: begin
        mem_req_d   = 1'b1;
        mem_we_d    = 1'b1;
        mem_addr_d  = addr_d + NEXT_OFFSET;
        mem_wdata_d = blk_d.next_ptr;
      end
      RESP: begin
        done_d = ~err_pend_d;
        err_d  = err_pend_d;
      end
      default: ;
    endcase
  end

  // State, captured request and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      addr_q      <= word_t'(0);
      blk_q       <= '0;
      err_pend_q  <= 1'b0;
      req_ready_q <= 1'b1;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= word_t'(0);
      mem_wdata_q <= word_t'(0);
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      blk_q       <= blk_d;
      err_pend_q  <= err_pend_d;
      req_ready_q <= req_ready_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign req_ready_o = req_ready_q;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign done_o      = done_q;
  assign err_o       = err_q;

endmodule

// File: doc/falafel_block_writer.md
FALAFEL_BLOCK_WRITER -- requirements
Module: falafel_block_writer

Interface
REQ-001 The block SHALL import falafel_pkg and use its word_t (64 bits), free_block_t {size, next_ptr} and NULL_PTR definitions.
REQ-002 The block SHALL have no parameters.
REQ-003 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_i  input  1  reset, synchronous and active-high.
REQ-005 req_valid_i  input  1  write-block request valid.
REQ-006 req_ready_o  output  1  block accepts a request; high only in IDLE.
REQ-007 req_addr_i  input  word_t  byte address of the free-block header.
REQ-008 req_block_i  input  free_block_t  header contents to write (size, next_ptr).
REQ-009 mem_req_o  output  1  memory request valid.
REQ-010 mem_gnt_i  input  1  memory accepts the current request.
REQ-011 mem_we_o  output  1  write enable; always 1 while mem_req_o=1.
REQ-012 mem_addr_o  output  word_t  memory byte address.
REQ-013 mem_wdata_o  output  word_t  memory write data.
REQ-014 mem_rvalid_i  input  1  write-completion acknowledge, one per granted request.
REQ-015 done_o  output  1  one-cycle pulse: header fully written.
REQ-016 err_o  output  1  one-cycle pulse: request rejected, no memory access issued.

Function
REQ-017 Header layout SHALL be: size at req_addr_i, next_ptr at req_addr_i+8 (64-bit add, wrap-around ignored).
REQ-018 Request SHALL be accepted on a cycle with req_valid_i=1 and req_ready_o=1; addr and block are captured into internal registers at acceptance.
REQ-019 Captured values SHALL be used for all subsequent beats; input changes after acceptance have no effect.
REQ-020 FSM states SHALL be IDLE, WR_SIZE, WAIT_SIZE, WR_NEXT, WAIT_NEXT, RESP.
REQ-021 IDLE -> RESP with err pending when accepted addr is NULL_PTR or addr[2:0]!=0; otherwise IDLE -> WR_SIZE.
REQ-022 WR_SIZE: mem_req_o=1, mem_addr_o=addr, mem_wdata_o=size; stays until mem_gnt_i=1, then -> WAIT_SIZE.
REQ-023 WAIT_SIZE: mem_req_o=0; on mem_rvalid_i=1 -> WR_NEXT.
REQ-024 WR_NEXT: mem_req_o=1, mem_addr_o=addr+8, mem_wdata_o=next_ptr; on mem_gnt_i=1 -> WAIT_NEXT.
REQ-025 WAIT_NEXT: on mem_rvalid_i=1 -> RESP with done pending.
REQ-026 RESP: asserts exactly one of done_o or err_o for one cycle, then -> IDLE; req_ready_o=0 in RESP.
REQ-027 Minimum latency acceptance-to-done_o with gnt and rvalid each returned the cycle after request SHALL be 5 cycles; err_o SHALL assert 1 cycle after acceptance.
REQ-028 mem_addr_o, mem_wdata_o and mem_we_o SHALL be stable while mem_req_o=1 and mem_gnt_i=0.
REQ-029 mem_gnt_i while mem_req_o=0 and mem_rvalid_i outside WAIT_SIZE/WAIT_NEXT SHALL be ignored.
REQ-030 At most one memory request SHALL be outstanding; the second beat is never issued before the first is acknowledged.
REQ-031 next_ptr=NULL_PTR SHALL be written normally (valid list tail), not an error.
REQ-032 size=0 SHALL be written normally; size is not checked.
REQ-033 When mem_req_o=0, mem_addr_o and mem_wdata_o SHALL be 0 and mem_we_o SHALL be 0.

Reset
REQ-034 rst_i=1 SHALL force IDLE on the next edge from any state, including mid-transaction; no completion pulse is produced for an aborted transaction.
REQ-035 Output values during and immediately after reset: req_ready_o=1, mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, done_o=0, err_o=0.
REQ-036 After reset, an mem_rvalid_i belonging to an aborted transaction SHALL be ignored.

Verification
REQ-037 addr=0x1000, size=0x40, next_ptr=0x2000, zero-wait memory -> writes (0x1000,0x40) then (0x1008,0x2000), done_o pulse at cycle 5, req_ready_o back high.
REQ-038 Same request, mem_gnt_i held low 3 cycles on each beat -> address/data stable throughout, done_o after both acks, no extra request.
REQ-039 addr=0x1004 -> err_o pulse 1 cycle after acceptance, mem_req_o never asserted; addr=NULL_PTR -> same.
REQ-040 next_ptr=NULL_PTR, size=0 -> both words written unchanged, done_o, err_o=0.
REQ-041 rst_i asserted in WAIT_SIZE, then stray mem_rvalid_i -> IDLE, no done_o/err_o, no second beat issued.
REQ-042 Back-to-back requests with req_valid_i held high -> second accepted only after RESP, inputs changed mid-transaction do not alter beats of the first.
